masked_subbytes_seq: RTL and testbench

MASKED_SUBBYTES_SEQ -- requirements
Module: masked_subbytes_seq

---
 rtl/aes_masked_pkg.sv | 23 ++
 rtl/sbox_valid_pipe.sv | 26 ++
 rtl/masked_subbytes_seq.sv | 105 ++++++++++
 tb/tb_masked_subbytes_seq.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_masked_pkg.sv
// Shared constants, FSM encoding and helpers for the masked AES datapath.
package aes_masked_pkg;

   localparam int NUM_BYTES = 16;
   localparam int BYTE_W    = 8;
   localparam int STATE_W   = NUM_BYTES * BYTE_W;
   localparam int CNT_W     = 4;

   localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NUM_BYTES - 1);

   typedef enum logic [1:0] {
      IDLE,
      FEED,
      DRAIN,
      DONE
   } fsm_t;

   // Byte counters stop at the last byte instead of wrapping.
   function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] c);
      return (c == LAST_BYTE) ? c : c + CNT_W'(1);
   endfunction

endpackage

// File: rtl/sbox_valid_pipe.sv
// Valid delay line matching the external S-box latency.
module sbox_valid_pipe #(
   parameter int SBOX_LATENCY = 5
) (
   input  logic ClkxCI,
   input  logic RstxBI,
   input  logic ValidxSI,
   output logic ValidxSO
);

   logic [SBOX_LATENCY-1:0] pipeQ;

   always_ff @(posedge ClkxCI or negedge RstxBI) begin
      if (!RstxBI) begin
         pipeQ <= '0;
      end else begin
         pipeQ[0] <= ValidxSI;
         for (int i = 1; i < SBOX_LATENCY; i++) begin
            pipeQ[i] <= pipeQ[i-1];
         end
      end
   end

   assign ValidxSO = pipeQ[SBOX_LATENCY-1];

endmodule

// File: rtl/masked_subbytes_seq.sv
// Byte-serial masked SubBytes sequencer around an external pipelined S-box.
module masked_subbytes_seq
   import aes_masked_pkg::*;
#(
   parameter int SHARES       = 2,
   parameter int SBOX_LATENCY = 5
) (
   input  logic                        ClkxCI,
   input  logic                        RstxBI,
   input  logic                        StartxSI,
   input  logic [STATE_W*SHARES-1:0]   StatexDI,
   output logic [BYTE_W*SHARES-1:0]    SboxInxDO,
   input  logic [BYTE_W*SHARES-1:0]    SboxOutxDI,
   output logic                        RndEnxSO,
   output logic                        BusyxSO,
   output logic                        DonexSO,
   output logic [STATE_W*SHARES-1:0]   StatexDO
);

   fsm_t                      fsmQ, fsmD;
   logic [STATE_W*SHARES-1:0] stateQ, stateD;
   logic [CNT_W-1:0]          feedCntQ, feedCntD;
   logic [CNT_W-1:0]          capCntQ, capCntD;
   logic                      feedValid;
   logic                      capValid;

   sbox_valid_pipe #(
      .SBOX_LATENCY(SBOX_LATENCY)
   ) u_valid_pipe (
      .ClkxCI  (ClkxCI),
      .RstxBI  (RstxBI),
      .ValidxSI(feedValid),
      .ValidxSO(capValid)
   );

   assign feedValid = (fsmQ == FEED);

   always_ff @(posedge ClkxCI or negedge RstxBI) begin
      if (!RstxBI) begin
         fsmQ     <= IDLE;
         stateQ   <= '0;
         feedCntQ <= '0;
         capCntQ  <= '0;
      end else begin
         fsmQ     <= fsmD;
         stateQ   <= stateD;
         feedCntQ <= feedCntD;
         capCntQ  <= capCntD;
      end
   end

   always_comb begin
      fsmD     = fsmQ;
      stateD   = stateQ;
      feedCntD = feedCntQ;
      capCntD  = capCntQ;
      unique case (fsmQ)
         IDLE: begin
            if (StartxSI) begin
               stateD   = StatexDI;
               feedCntD = '0;
               capCntD  = '0;
               fsmD     = FEED;
            end
         end
         FEED: begin
            feedCntD = satInc(feedCntQ);
            if (feedCntQ == LAST_BYTE) fsmD = DRAIN;
         end
         DRAIN: begin
            if (capValid && capCntQ == LAST_BYTE) fsmD = DONE;
         end
         DONE: begin
            fsmD = IDLE;
         end
         default: begin
            fsmD = IDLE;
         end
      endcase
      // Results land in place; each share is written only from its own lane.
      if (capValid && (fsmQ == FEED || fsmQ == DRAIN)) begin
         for (int s = 0; s < SHARES; s++) begin
            stateD[s*STATE_W + BYTE_W*int'(capCntQ) +: BYTE_W] =
               SboxOutxDI[s*BYTE_W +: BYTE_W];
         end
         capCntD = satInc(capCntQ);
      end
   end

   always_comb begin
      SboxInxDO = '0;
      if (fsmQ == FEED) begin
         for (int s = 0; s < SHARES; s++) begin
            SboxInxDO[s*BYTE_W +: BYTE_W] =
               stateQ[s*STATE_W + BYTE_W*int'(feedCntQ) +: BYTE_W];
         end
      end
   end

   assign BusyxSO  = (fsmQ != IDLE);
   assign RndEnxSO = BusyxSO;
   assign DonexSO  = (fsmQ == DONE);
   assign StatexDO = stateQ;

endmodule

// File: tb/tb_masked_subbytes_seq.sv
// Scoreboard bench: mock and masked-reference S-boxes around two DUT latencies.
module tb_masked_subbytes_seq;

   logic         ClkxCI;
   logic         RstxBI;
   logic         start, start0, start1;
   logic         sel, mode;
   logic [255:0] StatexDI;
   logic [15:0]  sbIn0, sbOut0, sbIn1, sbOut1;
   logic         rnd0, busy0, done0, rnd1, busy1, done1;
   logic [255:0] stO0, stO1;

   logic [255:0] stO;
   logic [15:0]  sbIn;
   logic         busy, done, rnd;

   logic [255:0] exq[$];
   int           total = 0;
   int           bad   = 0;

   assign start0 = start & ~sel;
   assign start1 = start & sel;
   assign stO    = sel ? stO1  : stO0;
   assign sbIn   = sel ? sbIn1 : sbIn0;
   assign busy   = sel ? busy1 : busy0;
   assign done   = sel ? done1 : done0;
   assign rnd    = sel ? rnd1  : rnd0;

   masked_subbytes_seq #(.SHARES(2), .SBOX_LATENCY(5)) u_dut0 (
      .ClkxCI    (ClkxCI),
      .RstxBI    (RstxBI),
      .StartxSI  (start0),
      .StatexDI  (StatexDI),
      .SboxInxDO (sbIn0),
      .SboxOutxDI(sbOut0),
      .RndEnxSO  (rnd0),
      .BusyxSO   (busy0),
      .DonexSO   (done0),
      .StatexDO  (stO0)
   );

   masked_subbytes_seq #(.SHARES(2), .SBOX_LATENCY(1)) u_dut1 (
      .ClkxCI    (ClkxCI),
      .RstxBI    (RstxBI),
      .StartxSI  (start1),
      .StatexDI  (StatexDI),
      .SboxInxDO (sbIn1),
      .SboxOutxDI(sbOut1),
      .RndEnxSO  (rnd1),
      .BusyxSO   (busy1),
      .DonexSO   (done1),
      .StatexDO  (stO1)
   );

   initial ClkxCI = 1'b0;
   always #5 ClkxCI = ~ClkxCI;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p = 8'h00; aa = a; bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
         bb = bb >> 1;
      end
      return p;
   endfunction

   // AES S-box without the 0x63 constant.
   function automatic logic [7:0] sbp(input logic [7:0] x);
      logic [7:0] v;
      v = 8'h00;
      for (int y = 1; y < 256; y++) begin
         if (gmul(x, 8'(y)) == 8'h01) v = 8'(y);
      end
      return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]}
               ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]};
   endfunction

   function automatic logic [15:0] mockF(input logic [15:0] x);
      logic [7:0] r;
      if (!mode) return {x[15:8], x[7:0] ^ 8'h5A};
      r = 8'($urandom);
      return {r, sbp(x[7:0] ^ x[15:8]) ^ r};
   endfunction

   logic [15:0] mk0 [5];
   logic [15:0] mk1;

   always @(posedge ClkxCI) begin
      mk0[0] <= mockF(sbIn0);
      for (int i = 1; i < 5; i++) mk0[i] <= mk0[i-1];
      mk1 <= mockF(sbIn1);
   end

   assign sbOut0 = mk0[4];
   assign sbOut1 = mk1;

   task automatic chk(input string tag, input logic [255:0] obs,
                      input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic chkZero(input string tag);
      chk({tag, "_state"}, stO, '0);
      chk({tag, "_sbin"}, {240'b0, sbIn}, '0);
      chk({tag, "_busy"}, {255'b0, busy}, '0);
      chk({tag, "_rnd"}, {255'b0, rnd}, '0);
      chk({tag, "_done"}, {255'b0, done}, '0);
   endtask

   function automatic logic [255:0] expOf(input bit m, input logic [255:0] st);
      logic [255:0] e;
      e = '0;
      for (int b = 0; b < 16; b++) begin
         if (!m) begin
            e[b*8 +: 8]       = st[b*8 +: 8] ^ 8'h5A;
            e[128 + b*8 +: 8] = st[128 + b*8 +: 8];
         end else begin
            e[b*8 +: 8] = sbp(st[b*8 +: 8] ^ st[128 + b*8 +: 8]);
         end
      end
      return e;
   endfunction

   function automatic logic [255:0] resView();
      return mode ? {128'b0, stO[127:0] ^ stO[255:128]} : stO;
   endfunction

   task automatic startRun(input bit s, input bit m, input logic [255:0] st);
      sel = s; mode = m; StatexDI = st;
      exq.push_back(expOf(m, st));
      start = 1'b1;
      @(posedge ClkxCI); #1;
      start = 1'b0;
      chk("e0_busy", {255'b0, busy}, 256'd1);
      chk("e0_sbin", {240'b0, sbIn}, {240'b0, st[135:128], st[7:0]});
   endtask

   task automatic run(input bit s, input bit m, input logic [255:0] st,
                      input bit pulse, input int expDone);
      int           doneCnt;
      logic [255:0] e, last;
      logic [15:0]  xin;
      doneCnt = 0;
      last = expOf(m, st);
      startRun(s, m, st);
      for (int n = 1; n <= 30; n++) begin
         start = pulse && (n == 5 || n == expDone + 1);
         @(posedge ClkxCI); #1;
         start = 1'b0;
         xin = (n < 16) ? {st[128 + n*8 +: 8], st[n*8 +: 8]} : 16'h0;
         chk($sformatf("busy_c%0d", n), {255'b0, busy}, {255'b0, n <= expDone});
         chk($sformatf("rnd_c%0d", n), {255'b0, rnd}, {255'b0, busy});
         chk($sformatf("done_c%0d", n), {255'b0, done}, {255'b0, n == expDone});
         chk($sformatf("sbin_c%0d", n), {240'b0, sbIn}, {240'b0, xin});
         if (done) begin
            doneCnt++;
            e = (exq.size() != 0) ? exq.pop_front() : 'x;
            chk("result", resView(), e);
         end
      end
      chk("done_count", doneCnt, 256'd1);
      chk("idle_hold", resView(), last);
   endtask

   logic [255:0] stA, stR;
   logic [127:0] r128, unm;

   initial begin
      RstxBI = 1'b0; start = 1'b0; sel = 1'b0; mode = 1'b0; StatexDI = '0;
      stA = '0;
      for (int b = 0; b < 16; b++) begin
         stA[b*8 +: 8]       = 8'(b);
         stA[128 + b*8 +: 8] = 8'hFF;
      end
      #12;
      sel = 1'b0; chkZero("rst0");
      sel = 1'b1; chkZero("rst1");
      @(posedge ClkxCI); #1 RstxBI = 1'b1;
      @(posedge ClkxCI); #1;

      run(1'b0, 1'b0, stA, 1'b0, 21);
      run(1'b0, 1'b0, stA, 1'b1, 21);

      startRun(1'b0, 1'b0, stA);
      for (int n = 1; n <= 8; n++) begin
         @(posedge ClkxCI); #1;
      end
      chk("mid_sbin8", {240'b0, sbIn}, {240'b0, 8'hFF, 8'h08});
      #3 RstxBI = 1'b0;
      #1 chkZero("midrst");
      @(posedge ClkxCI); @(posedge ClkxCI); #1 RstxBI = 1'b1;
      exq.delete();
      begin
         int dc;
         dc = 0;
         for (int n = 0; n < 30; n++) begin
            @(posedge ClkxCI); #1;
            if (done) dc++;
         end
         chk("no_done_after_rst", dc, 256'd0);
         chk("idle_after_rst", {255'b0, busy}, 256'd0);
      end
      stR = {$urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom, $urandom};
      run(1'b0, 1'b0, stR, 1'b0, 21);

      run(1'b1, 1'b0, stA, 1'b0, 17);
      stR = {$urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom, $urandom};
      run(1'b1, 1'b0, stR, 1'b0, 17);

      for (int j = 0; j < 16; j++) begin
         r128 = {$urandom, $urandom, $urandom, $urandom};
         for (int b = 0; b < 16; b++) unm[b*8 +: 8] = 8'(j*16 + b);
         run(1'b0, 1'b1, {r128, unm ^ r128}, 1'b0, 21);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
